// File: rtl/gate_share_pkg.sv
// Shared types for the gate_share_arbiter slice: opcode and FSM state encodings.
package gate_share_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOR  = 2'b00,
      OP_NAND = 2'b01,
      OP_XOR  = 2'b10,
      OP_AND  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/gate_share_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module gate_share_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [IDW-1:0]     last_grant_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDW-1:0]     idx_o,
   output logic               any_o
);

   logic [IDW:0]   cand_s;
   logic [IDW-1:0] cand_idx_s;

   // Walk the ring starting one past the last winner; the first hit is latched.
   always_comb begin
      grant_o    = '0;
      idx_o      = '0;
      any_o      = 1'b0;
      cand_s     = '0;
      cand_idx_s = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_s = {1'b0, last_grant_i} + (IDW+1)'(i);
         if (cand_s >= (IDW+1)'(NUM_REQ)) begin
            cand_s = cand_s - (IDW+1)'(NUM_REQ);
         end else begin
            cand_s = cand_s;
         end
         cand_idx_s = cand_s[IDW-1:0];
         if (!any_o && req_valid_i[cand_idx_s]) begin
            any_o               = 1'b1;
            idx_o               = cand_idx_s;
            grant_o[cand_idx_s] = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin time-shared NOR/NAND/XOR/AND unit with tagged valid/ready response.
// Optional: define GATE_SHARE_OPCNT_EN to add a saturating 16-bit op_count output.
module gate_share_arbiter
   import gate_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ*OP_W-1:0]    req_op,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]           rsp_data,
   input  logic                       rsp_ready
`ifdef GATE_SHARE_OPCNT_EN
   ,
   output logic [15:0]                op_count
`endif
);

   localparam int IDW = $clog2(NUM_REQ);

   function automatic logic [WIDTH-1:0] gate_eval(input op_e op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         OP_NOR:  r = ~(a | b);
         OP_NAND: r = ~(a & b);
         OP_XOR:  r = a ^ b;
         OP_AND:  r = a & b;
         default: r = '0;
      endcase
      return r;
   endfunction

   state_e             state_q;
   logic [WIDTH-1:0]   a_q, b_q, rsp_data_q;
   op_e                op_q;
   logic [IDW-1:0]     id_q, last_grant_q, rsp_id_q;
   logic               rsp_valid_q;

   logic [NUM_REQ-1:0] pick_gnt_s;
   logic [IDW-1:0]     pick_idx_s;
   logic               pick_any_s;
   logic               accept_s;
   logic [WIDTH-1:0]   sel_a_s, sel_b_s;
   op_e                sel_op_s;

   gate_share_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req_valid_i  (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_gnt_s),
      .idx_o        (pick_idx_s),
      .any_o        (pick_any_s)
   );

   // Ready only reaches the winner while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == ST_IDLE) && pick_any_s) begin
         req_ready = pick_gnt_s;
      end else begin
         req_ready = '0;
      end
   end

   // Winner's operands, muxed out of the packed request buses.
   always_comb begin
      sel_a_s  = req_a[pick_idx_s*WIDTH +: WIDTH];
      sel_b_s  = req_b[pick_idx_s*WIDTH +: WIDTH];
      sel_op_s = op_e'(req_op[pick_idx_s*OP_W +: OP_W]);
      accept_s = |(req_valid & req_ready);
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= OP_NOR;
         id_q         <= '0;
         last_grant_q <= IDW'(NUM_REQ-1);
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  a_q          <= sel_a_s;
                  b_q          <= sel_b_s;
                  op_q         <= sel_op_s;
                  id_q         <= pick_idx_s;
                  last_grant_q <= pick_idx_s;
                  state_q      <= ST_EXEC;
               end else begin
                  state_q      <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rsp_data_q  <= gate_eval(op_q, a_q, b_q);
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q     <= ST_RESP;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef GATE_SHARE_OPCNT_EN
   logic [15:0] op_count_q, op_count_d;

   // Count completed response handshakes, saturating at all-ones.
   always_comb begin
      op_count_d = op_count_q;
      if (rsp_valid_q && rsp_ready && (op_count_q != 16'hFFFF)) begin
         op_count_d = op_count_q + 16'd1;
      end else begin
         op_count_d = op_count_q;
      end
   end

   // Operation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q <= 16'd0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: doc/gate_share_arbiter.md
# gate_share_arbiter

Round-robin controller that time-shares one registered 2-input bitwise logic unit (NOR, NAND, XOR, AND) among `NUM_REQ` requesters. Each requester presents operands and an opcode over a valid/ready handshake. The arbiter grants one requester at a time, sequences the shared unit through a three-state FSM and returns a tagged result on a single response channel. It sits between the gate-level datapath library and any block that needs occasional wide logic operations without instantiating its own gates.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `WIDTH`, default 8: operand and result width in bits.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester request valid.
- `req_a`, in, `NUM_REQ*WIDTH`: operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`, in, `NUM_REQ*WIDTH`: operand B, same packing as `req_a`.
- `req_op`, in, `NUM_REQ*2`: opcode, 2 bits per requester. 00 NOR, 01 NAND, 10 XOR, 11 AND.
- `req_ready`, out, `NUM_REQ`: one-hot or zero; the request is accepted on an edge where `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, 1: result valid.
- `rsp_id`, out, `$clog2(NUM_REQ)`: index of the requester that owns the result.
- `rsp_data`, out, `WIDTH`: result.
- `rsp_ready`, in, 1: consumer accepts the response.

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, `req_ready` is driven combinationally to the winner's bit. On that edge, capture the winner's A, B, op and index, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute `op(A,B)` bitwise, register it into `rsp_data`, set `rsp_valid`, then go to RESP.
  - RESP: hold `rsp_valid`, `rsp_id` and `rsp_data` stable until `rsp_ready`. On the edge where `rsp_valid & rsp_ready`, clear `rsp_valid` and go to IDLE.
- Round-robin selection:
  - Search begins at `last_grant+1` and wraps modulo `NUM_REQ`. The first asserted `req_valid` wins.
  - `last_grant` updates to the winner only on accept.
- `req_ready` is all-zero in EXEC and RESP. Requesters keep `req_valid` and data stable until accepted.
- A requester may drop `req_valid` before it is accepted. It is then simply not selected, with no side effects.
- Opcode decode uses only captured values. Later changes on `req_*` do not affect an op in flight.

## Timing
- Reset values:
  - state IDLE
  - `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0
  - `last_grant` = `NUM_REQ-1`, so requester 0 has first priority
  - `req_ready` 0 while `rst_n` is low
- Latency: if the accept happens at edge k, `rsp_valid` rises after edge k+1.
- Minimum op period is 3 cycles: accept, EXEC, response handshake with `rsp_ready` held high.
- Backpressure: `rsp_ready` low holds the FSM in RESP indefinitely with outputs stable, and no new accept occurs.
- If all requesters are valid continuously, grants go 0,1,2,3,0,… with one grant per op period.
- A single continuous requester is re-granted on every IDLE visit.
- Asynchronous reset mid-operation abandons the in-flight op with no response. After release, the first grant follows the reset priority.

## Configuration
- `GATE_SHARE_OPCNT_EN` defined:
  - Adds output `op_count`, 16 bits, reset 0.
  - Increments on each response handshake and saturates at 0xFFFF.
- `GATE_SHARE_OPCNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `gate_share_pkg` holds:
  - the opcode enum (`OP_NOR`, `OP_NAND`, `OP_XOR`, `OP_AND`) and its width constant
  - the FSM state enum (IDLE, EXEC, RESP)
- Sub-module `gate_share_rr_pick` is purely combinational.
  - Inputs: the `req_valid` vector and `last_grant`.
  - Outputs: a one-hot grant and the winner index.
  - The top level gates its grant by state == IDLE.

## Test plan
- Reset, then requester 0 sends A=0x0F, B=0x33, op NOR with `rsp_ready`=1: expect `rsp_valid` 2 cycles after accept, `rsp_data`=0xC0, `rsp_id`=0.
- All four requesters valid (ops NOR, NAND, XOR, AND; A=0xAA, B=0xCC): expect grant order 0,1,2,3 and results 0x11, 0x77, 0x66, 0x88.
- Hold `rsp_ready`=0 for 10 cycles after a response appears: expect outputs stable, `req_ready`=0 throughout, and resume on release.
- Requester 2 alone, valid continuously: expect accepts every 3 cycles, all with `rsp_id`=2.
- Assert `rst_n` low during EXEC: expect `rsp_valid`=0 immediately, no response for the abandoned op, and the next grant goes to the lowest valid index.
- With `GATE_SHARE_OPCNT_EN` defined: after 5 responses expect `op_count`=5; force the counter to 0xFFFF and expect it to stay at 0xFFFF on the next response.
